shared_mem_slave: RTL

Avalon-MM slave responder for the word-addressed shared buffer that processor subsystems reach through their bridge master ports (10-bit word address, 32-bit data, burstcount 1). The block holds a dual-purpose word store: a byte-enabled RAM and one hardware test-and-set lock word used for inter-processor synchronisation. Reads are pipelined with fixed latency and `readdatavalid`. `waitrequest` throttles outstanding reads.

---
 rtl/shared_mem_slave_if.sv | 42 ++++
 rtl/shared_mem_slave.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/shared_mem_slave_if.sv
// ---------------------------------------------------------------------------
// shared_mem_slave_if
//
// Avalon-MM bus for the shared word buffer: 10-bit word address, 32-bit
// data, single-beat bursts only.
//
// Signals (seen from the slave):
//   s_address       in   word address
//   s_read          in   read request
//   s_write         in   write request
//   s_writedata     in   write data
//   s_byteenable    in   write byte lanes
//   s_burstcount    in   always 1, not used by the slave
//   s_debugaccess   in   not used by the slave
//   s_waitrequest   out  request not accepted this cycle
//   s_readdata      out  read response data
//   s_readdatavalid out  s_readdata valid this cycle
// ---------------------------------------------------------------------------
interface shared_mem_slave_if;
  logic [9:0]  s_address;
  logic        s_read;
  logic        s_write;
  logic [31:0] s_writedata;
  logic [3:0]  s_byteenable;
  logic        s_burstcount;
  logic        s_debugaccess;
  logic        s_waitrequest;
  logic [31:0] s_readdata;
  logic        s_readdatavalid;

  modport master (
    output s_address, s_read, s_write, s_writedata, s_byteenable,
           s_burstcount, s_debugaccess,
    input  s_waitrequest, s_readdata, s_readdatavalid
  );

  modport slave (
    input  s_address, s_read, s_write, s_writedata, s_byteenable,
           s_burstcount, s_debugaccess,
    output s_waitrequest, s_readdata, s_readdatavalid
  );
endinterface

// File: rtl/shared_mem_slave.sv
// ---------------------------------------------------------------------------
// shared_mem_slave
//
// Avalon-MM slave for the shared inter-processor buffer. It holds a 1024 x 32
// byte-enabled RAM plus one test-and-set lock word at LOCK_ADDR. Reads are
// pipelined with a fixed READ_LATENCY and at most MAX_PENDING reads can be
// outstanding; writes never stall.
//
// Ports:
//   clk_clk      in   sole clock, rising edge
//   reset_reset  in   asynchronous active-high reset
//   bus          slave modport of shared_mem_slave_if
//   lock_held    out  current (registered) lock state
// ---------------------------------------------------------------------------
module shared_mem_slave #(
  parameter int          READ_LATENCY = 2,       // 1..4
  parameter int          MAX_PENDING  = 4,       // 1..8
  parameter logic [9:0]  LOCK_ADDR    = 10'h3FF
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  shared_mem_slave_if.slave   bus,
  output logic                lock_held
);

  localparam int PW = $clog2(MAX_PENDING + 1);

  // Word store. Never reset: its contents survive reset by design.
  logic [31:0] mem [0:1023];
  logic [31:0] mem_rd_q;

  logic          addr_is_lock;
  logic          wait_int;
  logic          rd_acc;
  logic          wr_acc;
  logic          rvalid;

  logic [PW-1:0] pending_q, pending_d;
  logic          lock_q, lock_d;

  // First read stage: captured on the accepting edge, alongside mem_rd_q.
  logic          s0_valid_q, s0_valid_d;
  logic          s0_lock_q, s0_lock_d;
  logic          s0_lockval_q, s0_lockval_d;

  logic [READ_LATENCY-1:0]       stage_valid;
  logic [READ_LATENCY-1:0][31:0] stage_data;

  // Bus inputs that carry no information for this slave.
  logic unused_inputs;
  assign unused_inputs = ^{bus.s_burstcount, bus.s_debugaccess};

  assign addr_is_lock = (bus.s_address == LOCK_ADDR);

  // A read may still be accepted at the pending limit if a response retires
  // in the same cycle, which keeps one-per-cycle throughput at the limit.
  assign wait_int = reset_reset |
                    (bus.s_read & (pending_q == PW'(MAX_PENDING)) & ~rvalid);

  // When read and write coincide, the write wins and the read is dropped.
  assign rd_acc = bus.s_read & ~bus.s_write & ~wait_int;
  assign wr_acc = bus.s_write & ~wait_int;

  // RAM with byte-lane writes and a registered read. A read and a write can
  // never be accepted on the same edge, so there is no collision to resolve.
  always_ff @(posedge clk_clk) begin
    if (wr_acc && !addr_is_lock) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.s_byteenable[i]) begin
          mem[bus.s_address][8*i +: 8] <= bus.s_writedata[8*i +: 8];
        end
      end
    end
    if (rd_acc) begin
      mem_rd_q <= mem[bus.s_address];
    end
  end

  always_comb begin
    pending_d = pending_q;
    if (rd_acc && !rvalid) begin
      pending_d = pending_q + PW'(1);
    end else if (!rd_acc && rvalid) begin
      pending_d = pending_q - PW'(1);
    end

    // Test-and-set: a read of the lock word sets it; only a write with lane 0
    // enabled and bit 0 clear releases it. Anything else is a no-op.
    lock_d = lock_q;
    if (rd_acc && addr_is_lock) begin
      lock_d = 1'b1;
    end else if (wr_acc && addr_is_lock && bus.s_byteenable[0] &&
                 !bus.s_writedata[0]) begin
      lock_d = 1'b0;
    end

    s0_valid_d   = rd_acc;
    s0_lock_d    = addr_is_lock;
    s0_lockval_d = lock_q;            // lock value before this acceptance
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      pending_q    <= '0;
      lock_q       <= 1'b0;
      s0_valid_q   <= 1'b0;
      s0_lock_q    <= 1'b0;
      s0_lockval_q <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      lock_q       <= lock_d;
      s0_valid_q   <= s0_valid_d;
      s0_lock_q    <= s0_lock_d;
      s0_lockval_q <= s0_lockval_d;
    end
  end

  assign stage_valid[0] = s0_valid_q;
  assign stage_data[0]  = s0_lock_q ? {31'b0, s0_lockval_q} : mem_rd_q;

  // Remaining READ_LATENCY-1 delay stages. Valid bits reset so that reads in
  // flight at reset never produce a response.
  genvar gi;
  generate
    for (gi = 1; gi < READ_LATENCY; gi++) begin : g_pipe
      logic        v_q, v_d;
      logic [31:0] d_q, d_d;

      always_comb begin
        v_d = stage_valid[gi-1];
        d_d = stage_data[gi-1];
      end

      always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
          v_q <= 1'b0;
          d_q <= '0;
        end else begin
          v_q <= v_d;
          d_q <= d_d;
        end
      end

      assign stage_valid[gi] = v_q;
      assign stage_data[gi]  = d_q;
    end
  endgenerate

  assign rvalid              = stage_valid[READ_LATENCY-1];
  assign bus.s_readdatavalid = rvalid;
  assign bus.s_readdata      = rvalid ? stage_data[READ_LATENCY-1] : 32'h0;
  assign bus.s_waitrequest   = wait_int;
  assign lock_held           = lock_q;

endmodule
